edlo_sequencer: RTL and testbench
=================================

// Module: edlo_sequencer
// PURPOSE
//  Program sequencer for the EDLO datapath (ALU + memory controller). Loads a short
//  program of 8-bit words {inst[3:0], addr[3:0]}, then steps through it, issuing each
//  datapath instruction over a valid/ready handshake. Opcodes 4'hC-4'hF are consumed
//  internally for flow control; the ALU and memory controller never see them.
// PARAMETERS
//  ADDR_BITS   4    width of the datapath address field and of the program counter
//  PROG_DEPTH  16   program store entries; must be <= 2**ADDR_BITS
// PORTS
//  clock        in   1          rising-edge clock
//  reset        in   1          asynchronous, active-high; clears all state
//  load_valid   in   1          load_word is present
//  load_ready   out  1          high in IDLE while prog_len < PROG_DEPTH
//  load_word    in   8          {inst, addr}, appended at index prog_len
//  start        in   1          one-cycle pulse; begins execution at pc=0
//  abort        in   1          synchronous stop; returns to IDLE
//  issue_valid  out  1          inst/addr are valid for the datapath
//  issue_ready  in   1          datapath accepts the instruction this cycle
//  inst         out  4          opcode to ALU / memory controller
//  addr         out  ADDR_BITS  address operand
//  pc           out  ADDR_BITS  index of the current program word
//  running      out  1          high in FETCH, ISSUE or WAIT
//  done         out  1          one-cycle pulse on HALT or end of program
//  error        out  1          sticky until next start: empty program, or loop count 0 at LOOP
// BEHAVIOUR
//  Reset values: all outputs 0, except load_ready=1. prog_len=0, loop_cnt=0, state=IDLE.
//   Program store contents are not reset.
//  States: IDLE, FETCH, ISSUE, WAIT.
//  IDLE:  load_valid && load_ready -> store[prog_len] <= load_word; prog_len++.
//         start: if prog_len==0 -> done=1, error=1, stay IDLE.
//                else -> pc=0, clear error, go to FETCH.
//         start and load_valid in the same cycle: start wins and the word is dropped.
//  FETCH (1 cycle): registered read of store[pc]; decode.
//   4'hF HALT: done=1 -> IDLE.
//   4'hE JUMP: pc <= addr -> FETCH.
//   4'hD LDLC: loop_cnt <= addr; pc++ -> FETCH.
//   4'hC LOOP: loop_cnt!=0 -> loop_cnt--, and pc <= addr if the post-decrement
//              value is !=0, else pc++.
//              loop_cnt==0 -> error=1, pc++.
//   else: drive inst/addr, issue_valid=1 -> ISSUE.
//  ISSUE: inst/addr held stable while issue_valid && !issue_ready.
//   On issue_ready: issue_valid=0, pc++, -> FETCH. Each issued word leaves one bubble.
//  End of program: pc++ reaching prog_len -> done=1 -> IDLE. No wrap-around.
//   JUMP target >= prog_len behaves the same way.
//  abort: highest priority after reset, from any state; next cycle IDLE,
//   issue_valid=0, no done pulse. An in-flight instruction is withdrawn.
//  start while running is ignored. load_valid outside IDLE is ignored (load_ready=0).
//  Latency: start -> first issue_valid is 2 cycles.
//   Each flow-control opcode costs 1 cycle and issues nothing.
//  WAIT: reserved for a future datapath busy input. Unreachable now; decodes to IDLE.
//  Async reset mid-operation: issue_valid drops immediately, program is lost (prog_len=0).
// STRUCTURE
//  edlo_pkg: opcode constants OP_HALT=4'hF, OP_JUMP=4'hE, OP_LDLC=4'hD, OP_LOOP=4'hC;
//   state enum seq_state_t; the word-field split helpers.
//  One sub-module, seq_prog_mem: PROG_DEPTH x 8 register file, one write port,
//   registered read port, no reset.
//  The FSM, pc, prog_len and loop_cnt live in edlo_sequencer.
// TESTING
//  1. Load {1,3},{2,5},{F,0}; start; issue_ready=1 -> issues (1,3) then (2,5);
//     done pulses 2 cycles after the second accept.
//  2. Hold issue_ready=0 for 5 cycles on the first issue -> inst/addr/pc unchanged,
//     then accepted exactly once.
//  3. Load {D,3},{1,7},{C,1},{F,0} -> (1,7) issued 3 times; loop_cnt ends at 0;
//     no error.
//  4. Start with an empty program -> done=1 and error=1 in the same cycle;
//     running never rises.
//  5. Abort while issue_valid=1 -> IDLE next cycle; no done pulse; a restart issues
//     from pc=0.
//  6. Load 16 words -> load_ready=0 and a 17th word is ignored;
//     async reset mid-run -> all outputs return to reset values with no clock edge.

Source files
------------

// File: rtl/edlo_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : edlo_pkg
// | Description : Opcodes, sequencer state encoding and program-word field helpers
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
package edlo_pkg;

   localparam int WORD_W = 8;

   localparam logic [3:0] OP_HALT = 4'hF;
   localparam logic [3:0] OP_JUMP = 4'hE;
   localparam logic [3:0] OP_LDLC = 4'hD;
   localparam logic [3:0] OP_LOOP = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2,
      ST_WAIT  = 2'd3
   } seq_state_t;

   function automatic logic [3:0] word_inst(input logic [WORD_W-1:0] w);
      return w[7:4];
   endfunction

   function automatic logic [3:0] word_addr(input logic [WORD_W-1:0] w);
      return w[3:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_prog_mem.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : seq_prog_mem
// | Description : Program store, one write port and a registered read port
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module seq_prog_mem #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   // Contents deliberately survive reset; only the write pointer is cleared.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule
`default_nettype wire

// File: rtl/edlo_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : edlo_sequencer
// | Description : Loads and steps a short program, issuing datapath words over valid/ready
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module edlo_sequencer
   import edlo_pkg::*;
#(
   parameter int ADDR_BITS  = 4,
   parameter int PROG_DEPTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [WORD_W-1:0]    load_word,
   input  logic                 start,
   input  logic                 abort,
   output logic                 issue_valid,
   input  logic                 issue_ready,
   output logic [3:0]           inst,
   output logic [ADDR_BITS-1:0] addr,
   output logic [ADDR_BITS-1:0] pc,
   output logic                 running,
   output logic                 done,
   output logic                 error
);

   localparam int LEN_W = ADDR_BITS + 1;

   seq_state_t           r_state,    w_state_nxt;
   logic [ADDR_BITS-1:0] r_pc,       w_pc_nxt;
   logic [LEN_W-1:0]     r_prog_len, w_len_nxt;
   logic [ADDR_BITS-1:0] r_loop_cnt, w_cnt_nxt;
   logic [3:0]           r_inst,     w_inst_nxt;
   logic [ADDR_BITS-1:0] r_addr,     w_addr_nxt;
   logic                 r_done,     w_done_nxt;
   logic                 r_error,    w_error_nxt;

   logic                 w_we;
   logic [ADDR_BITS-1:0] w_rd_addr;
   logic [WORD_W-1:0]    w_rd_data;
   logic [3:0]           w_dec_inst;
   logic [ADDR_BITS-1:0] w_dec_addr;
   logic                 w_goto;
   logic [LEN_W-1:0]     w_target;
   logic [LEN_W-1:0]     w_pc_inc;

   seq_prog_mem #(
      .DEPTH (PROG_DEPTH),
      .AW    (ADDR_BITS),
      .DW    (WORD_W)
   ) u_prog_mem (
      .clk     (clock),
      .i_we    (w_we),
      .i_waddr (r_prog_len[ADDR_BITS-1:0]),
      .i_wdata (load_word),
      .i_raddr (w_rd_addr),
      .o_rdata (w_rd_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_pc       <= '0;
         r_prog_len <= '0;
         r_loop_cnt <= '0;
         r_inst     <= '0;
         r_addr     <= '0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_prog_len <= w_len_nxt;
         r_loop_cnt <= w_cnt_nxt;
         r_inst     <= w_inst_nxt;
         r_addr     <= w_addr_nxt;
         r_done     <= w_done_nxt;
         r_error    <= w_error_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_len_nxt   = r_prog_len;
      w_cnt_nxt   = r_loop_cnt;
      w_inst_nxt  = r_inst;
      w_addr_nxt  = r_addr;
      w_done_nxt  = 1'b0;
      w_error_nxt = r_error;
      w_we        = 1'b0;
      w_rd_addr   = r_pc;
      w_goto      = 1'b0;
      w_target    = '0;
      w_dec_inst  = word_inst(w_rd_data);
      w_dec_addr  = ADDR_BITS'(word_addr(w_rd_data));
      w_pc_inc    = LEN_W'(r_pc) + LEN_W'(1);

      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (r_prog_len == '0) begin
                     w_done_nxt  = 1'b1;
                     w_error_nxt = 1'b1;
                  end else begin
                     w_error_nxt = 1'b0;
                     w_goto      = 1'b1;
                     w_target    = '0;
                  end
               end else if (load_valid && load_ready) begin
                  w_we      = 1'b1;
                  w_len_nxt = r_prog_len + LEN_W'(1);
               end
            end
            ST_FETCH: begin
               case (w_dec_inst)
                  OP_HALT: begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
                  OP_JUMP: begin
                     w_goto   = 1'b1;
                     w_target = LEN_W'(w_dec_addr);
                  end
                  OP_LDLC: begin
                     w_cnt_nxt = w_dec_addr;
                     w_goto    = 1'b1;
                     w_target  = w_pc_inc;
                  end
                  OP_LOOP: begin
                     w_goto   = 1'b1;
                     w_target = w_pc_inc;
                     if (r_loop_cnt != '0) begin
                        w_cnt_nxt = r_loop_cnt - ADDR_BITS'(1);
                        // Branch back only while the decremented count is still non-zero.
                        if (r_loop_cnt != ADDR_BITS'(1)) begin
                           w_target = LEN_W'(w_dec_addr);
                        end
                     end else begin
                        w_error_nxt = 1'b1;
                     end
                  end
                  default: begin
                     w_inst_nxt  = w_dec_inst;
                     w_addr_nxt  = w_dec_addr;
                     w_state_nxt = ST_ISSUE;
                  end
               endcase
            end
            ST_ISSUE: begin
               if (issue_ready) begin
                  w_goto   = 1'b1;
                  w_target = w_pc_inc;
               end
            end
            ST_WAIT: begin
               w_state_nxt = ST_IDLE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase

         // Any pc move past the loaded program ends the run without wrapping.
         if (w_goto) begin
            if (w_target >= r_prog_len) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_pc_nxt    = w_target[ADDR_BITS-1:0];
               w_rd_addr   = w_target[ADDR_BITS-1:0];
               w_state_nxt = ST_FETCH;
            end
         end
      end
   end

   assign load_ready  = (r_state == ST_IDLE) && (r_prog_len < LEN_W'(PROG_DEPTH));
   assign issue_valid = (r_state == ST_ISSUE);
   assign running     = (r_state != ST_IDLE);
   assign inst        = r_inst;
   assign addr        = r_addr;
   assign pc          = r_pc;
   assign done        = r_done;
   assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_edlo_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module      : tb_edlo_sequencer
// | Description : Directed scoreboard bench for the EDLO program sequencer
// | Revision    : 1.0 - initial release
// +-----------------------------------------------------------------------------
module tb_edlo_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load_valid = 1'b0;
   logic       load_ready;
   logic [7:0] load_word = '0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       issue_valid;
   logic       issue_ready = 1'b0;
   logic [3:0] inst;
   logic [3:0] addr;
   logic [3:0] pc;
   logic       running;
   logic       done;
   logic       error;

   typedef struct packed {
      logic [3:0] inst;
      logic [3:0] addr;
      logic [3:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   n_acc    = 0;
   int   cyc      = 0;
   int   last_acc = 0;

   edlo_sequencer #(.ADDR_BITS(4), .PROG_DEPTH(16)) dut (
      .clock       (clk),
      .reset       (rst),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_word   (load_word),
      .start       (start),
      .abort       (abort),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .inst        (inst),
      .addr        (addr),
      .pc          (pc),
      .running     (running),
      .done        (done),
      .error       (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted handshake is compared against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && issue_valid === 1'b1 && issue_ready === 1'b1) begin
         n_acc++;
         last_acc = cyc;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_issue: got inst=%0h addr=%0h pc=%0h, none expected",
                     inst, addr, pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("issue_word", int'({inst, addr, pc}), int'({e.inst, e.addr, e.pc}));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic load(input int i, input int a);
      logic [31:0] iv, av;
      iv = i;
      av = a;
      load_valid = 1'b1;
      load_word  = {iv[3:0], av[3:0]};
      step();
      load_valid = 1'b0;
   endtask

   task automatic push(input int i, input int a, input int p);
      exp_t e;
      logic [31:0] iv, av, pv;
      iv = i; av = a; pv = p;
      e.inst = iv[3:0];
      e.addr = av[3:0];
      e.pc   = pv[3:0];
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done === 1'b1) break;
      end
      chk(name, int'(k < budget), 1);
   endtask

   task automatic wait_valid(input string name, input int budget);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (issue_valid === 1'b1) break;
      end
      chk(name, int'(k < budget), 1);
   endtask

   initial begin
      int base;
      // Reset values, applied without any clock edge.
      #1 rst = 1'b1;
      #1;
      chk("rst_load_ready", int'(load_ready), 1);
      chk("rst_outputs", int'({issue_valid, inst, addr, pc, running, done, error}), 0);
      step();
      rst = 1'b0;

      // 1: straight-line program, latency and done timing
      do_reset();
      load(1, 3); load(2, 5); load(15, 0);
      push(1, 3, 0); push(2, 5, 1);
      issue_ready = 1'b1;
      pulse_start();
      @(negedge clk);
      chk("t1_lat_c1", int'({issue_valid, running}), 2'b01);
      @(negedge clk);
      chk("t1_lat_c2", int'(issue_valid), 1);
      wait_done("t1_done_seen", 20);
      chk("t1_done_delay", cyc - last_acc, 2);
      chk("t1_err", int'(error), 0);
      @(negedge clk);
      chk("t1_done_pulse", int'({done, running}), 0);
      chk("t1_q_empty", exp_q.size(), 0);
      issue_ready = 1'b0;

      // 2: back-pressure holds the word stable, accepted once
      do_reset();
      load(1, 3); load(2, 5); load(15, 0);
      push(1, 3, 0); push(2, 5, 1);
      base = n_acc;
      pulse_start();
      wait_valid("t2_valid", 10);
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold", int'({issue_valid, inst, addr, pc}), {1'b1, 4'h1, 4'h3, 4'h0});
         step();
         @(negedge clk);
      end
      chk("t2_no_acc", n_acc - base, 0);
      step();
      issue_ready = 1'b1;
      step();
      issue_ready = 1'b0;
      chk("t2_one_acc", n_acc - base, 1);
      wait_valid("t2_valid2", 10);
      chk("t2_second", int'({inst, addr, pc}), {4'h2, 4'h5, 4'h1});
      step();
      issue_ready = 1'b1;
      wait_done("t2_done", 20);
      chk("t2_total_acc", n_acc - base, 2);
      issue_ready = 1'b0;

      // 3: LDLC/LOOP repeats the body three times
      do_reset();
      load(13, 3); load(1, 7); load(12, 1); load(15, 0);
      push(1, 7, 1); push(1, 7, 1); push(1, 7, 1);
      issue_ready = 1'b1;
      pulse_start();
      wait_done("t3_done", 60);
      chk("t3_err", int'(error), 0);
      chk("t3_loop_cnt", int'(dut.r_loop_cnt), 0);
      chk("t3_q_empty", exp_q.size(), 0);
      issue_ready = 1'b0;

      // 4: empty program
      do_reset();
      pulse_start();
      @(negedge clk);
      chk("t4_done_err", int'({done, error, running}), 3'b110);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_idle", int'({done, error, running}), 3'b010);
      end

      // 5: abort withdraws the in-flight word; restart runs from pc 0
      do_reset();
      load(1, 3); load(2, 5); load(15, 0);
      pulse_start();
      wait_valid("t5_valid", 10);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_aborted", int'({issue_valid, running, done}), 0);
      end
      push(1, 3, 0); push(2, 5, 1);
      issue_ready = 1'b1;
      step();
      pulse_start();
      wait_done("t5_restart_done", 20);
      chk("t5_q_empty", exp_q.size(), 0);
      issue_ready = 1'b0;

      // 6: full program store, overflow word ignored, async reset mid-run
      do_reset();
      for (int i = 0; i < 16; i++) load(i % 12, i);
      chk("t6_full", int'(load_ready), 0);
      load(15, 0);
      for (int i = 0; i < 16; i++) push(i % 12, i, i);
      issue_ready = 1'b1;
      pulse_start();
      wait_done("t6_done", 100);
      chk("t6_q_empty", exp_q.size(), 0);
      for (int i = 0; i < 16; i++) push(i % 12, i, i);
      base = n_acc;
      step();
      pulse_start();
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (n_acc - base >= 4 && issue_valid === 1'b1) break;
      end
      chk("t6_midrun", int'(issue_valid), 1);
      #2 rst = 1'b1;
      #1;
      exp_q.delete();
      chk("t6_async_ready", int'(load_ready), 1);
      chk("t6_async_outs", int'({issue_valid, inst, addr, pc, running, done, error}), 0);
      issue_ready = 1'b0;
      step();
      rst = 1'b0;
      pulse_start();
      @(negedge clk);
      chk("t6_prog_lost", int'({done, error}), 2'b11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
